// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: byte-level request/response responder between a UART
// rx/tx pair and an 8-bit register bus.
//   Requests: 0x57 addr data -> write, answered 0x4B
//             0x52 addr      -> read, answered with the register byte
//             anything else  -> answered 0x3F
// Ports:
//   i_SysClock, i_Reset            clock, synchronous active-high reset
//   i_RxByte, i_RxDone             received byte + completion (edge-detected)
//   o_TxByte, o_TxValid, i_TxDone  response byte handshake with uart_tx
//   o_RegAddr, o_RegWrData         register bus address / write data
//   o_RegWr, o_RegRd, i_RegRdData  one-cycle strobes, read data
//   o_Busy, o_Overrun              not-idle flag, dropped-byte pulse
module uart_reg_bridge #(
  parameter int unsigned SYS_CLOCK     = 50000000,
  parameter int unsigned UART_BAUDRATE = 115200,
  parameter int unsigned TIMEOUT_BITS  = 20
) (
  input  logic       i_SysClock,
  input  logic       i_Reset,
  input  logic [7:0] i_RxByte,
  input  logic       i_RxDone,
  output logic [7:0] o_TxByte,
  output logic       o_TxValid,
  input  logic       i_TxDone,
  output logic [7:0] o_RegAddr,
  output logic [7:0] o_RegWrData,
  output logic       o_RegWr,
  output logic       o_RegRd,
  input  logic [7:0] i_RegRdData,
  output logic       o_Busy,
  output logic       o_Overrun
);

  localparam int unsigned TimeoutCycles = TIMEOUT_BITS * SYS_CLOCK / UART_BAUDRATE;
  localparam logic [31:0] TimeoutLast   = 32'(TimeoutCycles - 1);

  localparam logic [7:0] CmdWrite = 8'h57;
  localparam logic [7:0] CmdRead  = 8'h52;
  localparam logic [7:0] RspAck   = 8'h4B;
  localparam logic [7:0] RspErr   = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE, ST_GET_ADDR, ST_GET_DATA, ST_REG_WRITE,
    ST_REG_READ, ST_READ_WAIT, ST_SEND, ST_SEND_GAP
  } state_e;

  state_e      state_q, state_d;
  logic        rx_done_q, tx_done_q;
  logic        rx_rise, tx_rise, to_expire;
  logic [31:0] to_cnt_q, to_cnt_d;
  logic        wr_flag_q, wr_flag_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        tx_valid_q, tx_valid_d;
  logic        reg_wr_q, reg_wr_d;
  logic        reg_rd_q, reg_rd_d;
  logic        busy_q, busy_d;
  logic        overrun_q, overrun_d;

  assign rx_rise   = i_RxDone & ~rx_done_q;
  assign tx_rise   = i_TxDone & ~tx_done_q;
  // An arriving byte takes priority over an expiring timeout
  assign to_expire = ((state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA)) &&
                     !rx_rise && (to_cnt_q == TimeoutLast);

  // State register, edge-detect history and timeout counter
  always_ff @(posedge i_SysClock) begin
    if (i_Reset) begin
      state_q   <= ST_IDLE;
      rx_done_q <= 1'b0;
      tx_done_q <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      rx_done_q <= i_RxDone;
      tx_done_q <= i_TxDone;
      to_cnt_q  <= to_cnt_d;
    end
  end

  // Next-state logic; the counter only advances while waiting for frame bytes
  always_comb begin
    state_d  = state_q;
    to_cnt_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_rise) begin
          if ((i_RxByte == CmdWrite) || (i_RxByte == CmdRead)) state_d = ST_GET_ADDR;
          else state_d = ST_SEND;
        end
      end
      ST_GET_ADDR: begin
        if (rx_rise)        state_d = wr_flag_q ? ST_GET_DATA : ST_REG_READ;
        else if (to_expire) state_d = ST_IDLE;
        else                to_cnt_d = to_cnt_q + 32'd1;
      end
      ST_GET_DATA: begin
        if (rx_rise)        state_d = ST_REG_WRITE;
        else if (to_expire) state_d = ST_IDLE;
        else                to_cnt_d = to_cnt_q + 32'd1;
      end
      ST_REG_WRITE: state_d = ST_SEND;
      ST_REG_READ:  state_d = ST_READ_WAIT;
      ST_READ_WAIT: state_d = ST_SEND;
      ST_SEND:      if (tx_rise) state_d = ST_SEND_GAP;
      ST_SEND_GAP:  state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and frame fields
  always_comb begin
    tx_byte_d  = tx_byte_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_flag_d  = wr_flag_q;
    tx_valid_d = 1'b0;
    reg_wr_d   = 1'b0;
    reg_rd_d   = 1'b0;
    overrun_d  = 1'b0;
    busy_d     = (state_d != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (rx_rise) begin
          wr_flag_d = (i_RxByte == CmdWrite);
          if ((i_RxByte != CmdWrite) && (i_RxByte != CmdRead)) tx_byte_d = RspErr;
        end
      end
      ST_GET_ADDR: if (rx_rise) addr_d = i_RxByte;
      ST_GET_DATA: if (rx_rise) wdata_d = i_RxByte;
      ST_REG_WRITE: begin
        reg_wr_d  = 1'b1;
        tx_byte_d = RspAck;
        overrun_d = rx_rise;
      end
      ST_REG_READ: begin
        reg_rd_d  = 1'b1;
        overrun_d = rx_rise;
      end
      ST_READ_WAIT: begin
        tx_byte_d = i_RegRdData;
        overrun_d = rx_rise;
      end
      // Valid drops on the same edge the TX completion is seen
      ST_SEND: begin
        tx_valid_d = !tx_rise;
        overrun_d  = rx_rise;
      end
      ST_SEND_GAP: overrun_d = rx_rise;
      default: ;
    endcase
  end

  // Output and frame-field registers
  always_ff @(posedge i_SysClock) begin
    if (i_Reset) begin
      tx_byte_q  <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_flag_q  <= 1'b0;
      tx_valid_q <= 1'b0;
      reg_wr_q   <= 1'b0;
      reg_rd_q   <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      tx_byte_q  <= tx_byte_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_flag_q  <= wr_flag_d;
      tx_valid_q <= tx_valid_d;
      reg_wr_q   <= reg_wr_d;
      reg_rd_q   <= reg_rd_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign o_TxByte    = tx_byte_q;
  assign o_TxValid   = tx_valid_q;
  assign o_RegAddr   = addr_q;
  assign o_RegWrData = wdata_q;
  assign o_RegWr     = reg_wr_q;
  assign o_RegRd     = reg_rd_q;
  assign o_Busy      = busy_q;
  assign o_Overrun   = overrun_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed bench for uart_reg_bridge with a small register-file model.
module tb_uart_reg_bridge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_done = 1'b0;
  logic       tx_done = 1'b0;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_wr, reg_rd, busy, overrun;

  logic [7:0] regs [256];

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0, rd_cnt = 0, ovr_cnt = 0, tx_starts = 0, both_cnt = 0;
  logic txv_prev = 1'b0;
  int wr0, rd0, ov0, ts0;

  uart_reg_bridge #(
    .SYS_CLOCK(1000), .UART_BAUDRATE(100), .TIMEOUT_BITS(2)
  ) dut (
    .i_SysClock(clk), .i_Reset(rst),
    .i_RxByte(rx_byte), .i_RxDone(rx_done),
    .o_TxByte(tx_byte), .o_TxValid(tx_valid), .i_TxDone(tx_done),
    .o_RegAddr(reg_addr), .o_RegWrData(reg_wdata),
    .o_RegWr(reg_wr), .o_RegRd(reg_rd), .i_RegRdData(reg_rdata),
    .o_Busy(busy), .o_Overrun(overrun)
  );

  always #5 clk = ~clk;

  // Register model: combinational read, write on strobe
  assign reg_rdata = regs[reg_addr];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) regs[i] <= 8'h00;
      regs[8'h34] <= 8'h5C;
    end else if (reg_wr) begin
      regs[reg_addr] <= reg_wdata;
    end
  end

  // Event counters sampled mid-cycle
  always @(negedge clk) begin
    if (reg_wr) wr_cnt++;
    if (reg_rd) rd_cnt++;
    if (overrun) ovr_cnt++;
    if (reg_wr && reg_rd) both_cnt++;
    if (tx_valid === 1'b1 && txv_prev !== 1'b1) tx_starts++;
    txv_prev = tx_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Byte is sampled on the first edge; returns 1 ns after the following edge
  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
    step();
  endtask

  // Completes the TX handshake and lets SEND_GAP pass
  task automatic finish_tx();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("txvalid_low_after_done", tx_valid, 1'b0);
    step();
    check("idle_after_gap", busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    check("rst_txvalid", tx_valid, 1'b0);
    check("rst_txbyte", tx_byte, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_strobes", {reg_wr, reg_rd, overrun}, 3'b000);
    rst = 1'b0;
    step();

    // Write 0x57 0x12 0xA5
    wr0 = wr_cnt;
    send_byte(8'h57);
    check("wr_busy", busy, 1'b1);
    send_byte(8'h12);
    send_byte(8'hA5);
    check("wr_strobe_n1", reg_wr, 1'b1);
    check("wr_addr", reg_addr, 8'h12);
    check("wr_data", reg_wdata, 8'hA5);
    check("wr_txvalid_n1", tx_valid, 1'b0);
    step();
    check("wr_strobe_n2", reg_wr, 1'b0);
    check("wr_txvalid_n2", tx_valid, 1'b1);
    check("wr_txbyte", tx_byte, 8'h4B);
    check("wr_busy_send", busy, 1'b1);
    finish_tx();
    check("wr_count", 32'(wr_cnt - wr0), 32'd1);
    check("wr_reg_model", regs[8'h12], 8'hA5);

    // Read 0x52 0x12
    rd0 = rd_cnt;
    send_byte(8'h52);
    send_byte(8'h12);
    check("rd_strobe_n1", reg_rd, 1'b1);
    step();
    check("rd_strobe_n2", reg_rd, 1'b0);
    check("rd_txvalid_n2", tx_valid, 1'b0);
    step();
    check("rd_txvalid_n3", tx_valid, 1'b1);
    check("rd_txbyte", tx_byte, 8'hA5);
    repeat (4) step();
    check("rd_txvalid_held", tx_valid, 1'b1);
    check("rd_txbyte_held", tx_byte, 8'hA5);
    finish_tx();
    check("rd_count", 32'(rd_cnt - rd0), 32'd1);

    // Unknown commands 0x00 and 0xFF
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    send_byte(8'h00);
    check("unk0_txvalid", tx_valid, 1'b1);
    check("unk0_txbyte", tx_byte, 8'h3F);
    finish_tx();
    send_byte(8'hFF);
    check("unk1_txvalid", tx_valid, 1'b1);
    check("unk1_txbyte", tx_byte, 8'h3F);
    finish_tx();
    check("unk_no_strobes", 32'((wr_cnt - wr0) + (rd_cnt - rd0)), 32'd0);

    // Timeout after 0x57 0x34 (20-cycle limit)
    wr0 = wr_cnt;
    ts0 = tx_starts;
    send_byte(8'h57);
    send_byte(8'h34);
    repeat (18) step();
    check("to_busy_before_expiry", busy, 1'b1);
    step();
    check("to_idle_at_expiry", busy, 1'b0);
    repeat (6) step();
    check("to_no_write", 32'(wr_cnt - wr0), 32'd0);
    check("to_no_tx", 32'(tx_starts - ts0), 32'd0);
    check("to_txvalid", tx_valid, 1'b0);
    send_byte(8'h52);
    send_byte(8'h34);
    step();
    step();
    check("to_read_txvalid", tx_valid, 1'b1);
    check("to_read_txbyte", tx_byte, 8'h5C);
    finish_tx();

    // Overrun: byte arrives while responding
    ov0 = ovr_cnt;
    send_byte(8'h00);
    check("ovr_in_send", tx_valid, 1'b1);
    rx_byte = 8'h57;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
    check("ovr_pulse", overrun, 1'b1);
    check("ovr_tx_unchanged", tx_byte, 8'h3F);
    step();
    check("ovr_pulse_end", overrun, 1'b0);
    check("ovr_txvalid_kept", tx_valid, 1'b1);
    finish_tx();
    check("ovr_count", 32'(ovr_cnt - ov0), 32'd1);
    send_byte(8'h57);
    send_byte(8'h40);
    send_byte(8'h77);
    check("ovr_next_wr", {reg_wr, reg_addr, reg_wdata}, {1'b1, 8'h40, 8'h77});
    step();
    check("ovr_next_ack", tx_byte, 8'h4B);
    finish_tx();

    // RX and TX completion on the same edge in SEND
    ov0 = ovr_cnt;
    send_byte(8'h11);
    rx_byte = 8'h52;
    rx_done = 1'b1;
    tx_done = 1'b1;
    step();
    rx_done = 1'b0;
    tx_done = 1'b0;
    check("sim_txvalid", tx_valid, 1'b0);
    check("sim_overrun", overrun, 1'b1);
    step();
    check("sim_idle", busy, 1'b0);

    // Reset mid-frame
    wr0 = wr_cnt;
    send_byte(8'h57);
    send_byte(8'h01);
    rst = 1'b1;
    step();
    check("rst_mid_outputs",
          {tx_byte, tx_valid, reg_addr, reg_wdata, reg_wr, reg_rd, busy, overrun}, 30'd0);
    rst = 1'b0;
    step();
    send_byte(8'h57);
    send_byte(8'h01);
    send_byte(8'h02);
    check("rst_wr", {reg_wr, reg_addr, reg_wdata}, {1'b1, 8'h01, 8'h02});
    step();
    finish_tx();
    check("rst_wr_count", 32'(wr_cnt - wr0), 32'd1);
    check("rst_reg_model", regs[8'h01], 8'h02);
    check("never_both_strobes", both_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_reg_bridge.md
Name: uart_reg_bridge

Overview:
Byte-level command responder that sits between the existing uart_rx/uart_tx pair and an 8-bit internal register bus. It decodes host request frames arriving as received bytes, performs register reads and writes, and returns one response byte per completed request through uart_tx. Operation is half-duplex request/response. It is the device-side counterpart of a host that initiates register accesses over the UART link.

Parameters:
SYS_CLOCK, 50000000, system clock frequency in Hz
UART_BAUDRATE, 115200, link baud rate
TIMEOUT_BITS, 20, inter-byte timeout in bit-times; TimeoutCycles = TIMEOUT_BITS*SYS_CLOCK/UART_BAUDRATE (8680 at defaults)

Ports:
i_SysClock  in  1  system clock; all logic on rising edge
i_Reset  in  1  synchronous, active-high reset
i_RxByte  in  8  received byte from uart_rx; valid when i_RxDone rises
i_RxDone  in  1  uart_rx byte-complete; rising edge detected internally, so pulse or level both accepted
o_TxByte  out  8  response byte to uart_tx; stable while o_TxValid=1
o_TxValid  out  1  request to uart_tx; held until i_TxDone rises
i_TxDone  in  1  uart_tx frame-complete; rising edge detected internally
o_RegAddr  out  8  register address
o_RegWrData  out  8  register write data
o_RegWr  out  1  one-cycle write strobe
o_RegRd  out  1  one-cycle read strobe
i_RegRdData  in  8  read data; valid the cycle after o_RegRd
o_Busy  out  1  high in any state other than IDLE
o_Overrun  out  1  one-cycle pulse when a byte is dropped during a response

Behaviour:
- Reset (i_Reset=1 at a clock edge): state IDLE. o_TxByte=0, o_TxValid=0, o_RegAddr=0, o_RegWrData=0, o_RegWr=0, o_RegRd=0, o_Busy=0, o_Overrun=0. Edge-detect history registers and the timeout counter clear. Reset mid-frame or mid-response aborts immediately and sends no response. The bridge makes no guarantee about a uart_tx frame already in flight.
- Frames: write = 0x57, addr, data, answered with 0x4B. Read = 0x52, addr, answered with the register data byte. Any other first byte is answered with 0x3F.
- States: IDLE, GET_ADDR, GET_DATA, REG_WRITE, REG_READ, READ_WAIT, SEND, SEND_GAP.
- IDLE:
  - rx 0x57 -> GET_ADDR, write flag set.
  - rx 0x52 -> GET_ADDR, write flag clear.
  - other byte -> SEND with 0x3F.
- GET_ADDR: rx -> latch o_RegAddr. Then GET_DATA if the write flag is set, otherwise REG_READ.
- GET_DATA: rx -> latch o_RegWrData -> REG_WRITE.
- REG_WRITE: o_RegWr=1 for exactly one cycle. Load o_TxByte=0x4B -> SEND.
- REG_READ: o_RegRd=1 for exactly one cycle -> READ_WAIT.
- READ_WAIT: capture i_RegRdData into o_TxByte -> SEND.
- SEND: o_TxValid=1 with o_TxByte held. On an i_TxDone rising edge: o_TxValid=0 -> SEND_GAP.
- SEND_GAP: one cycle with o_TxValid=0 -> IDLE. This guarantees uart_tx sees TxValid low between bytes.
- Latency, with the final request byte's i_RxDone edge at cycle N:
  - write: o_RegWr at N+1, o_TxValid at N+2.
  - read: o_RegRd at N+1, data sampled at N+2, o_TxValid at N+3.
  - unknown command: o_TxValid at N+1.
- Timeout: a 32-bit counter runs only in GET_ADDR/GET_DATA and clears on each accepted byte. When it reaches TimeoutCycles-1, the partial frame is discarded, state returns to IDLE, and no response or register strobe is issued.
- Bytes received in REG_WRITE, REG_READ, READ_WAIT, SEND or SEND_GAP are discarded and o_Overrun pulses for one cycle. They are never queued.
- Simultaneous events:
  - An i_RxDone edge in the same cycle as timeout expiry: the byte wins and the counter clears.
  - An i_RxDone edge in the same cycle as i_TxDone in SEND: the TX completes and the byte is dropped with o_Overrun.
- o_RegWr and o_RegRd are never both high, and each is high for at most one cycle per frame.

Test Plan:
- Write 0x57,0x12,0xA5 -> one-cycle o_RegWr with o_RegAddr=0x12 and o_RegWrData=0xA5, at cycle N+1 after the third byte; TX sends 0x4B; o_Busy falls after SEND_GAP.
- Read 0x52,0x12, with a bench register model returning 0xA5 -> o_RegRd at N+1; TX byte 0xA5; o_TxValid stays high until i_TxDone, then is low for ≥1 cycle.
- Unknown byte 0x00, then 0xFF -> TX sends 0x3F twice; no o_RegWr/o_RegRd.
- Timeout, with TIMEOUT_BITS=2, SYS_CLOCK=1000, UART_BAUDRATE=100 (20 cycles): send 0x57,0x34, then idle 25 cycles -> no strobe, no TX, state IDLE; a following 0x52,0x34 reads normally.
- Overrun: inject a byte while in SEND -> o_Overrun pulses once; response is unchanged; next frame is decoded correctly.
- Reset: assert i_Reset after 0x57,0x01 -> all outputs 0 the next cycle; then 0x57,0x01,0x02 -> a single write, addr 0x01, data 0x02.
